// File: rtl/stage_mem_hs.sv
// stage_mem_hs: pipeline memory stage between EXE and WB with a req/ack bus,
// byte/half/word access, alignment checking and a bounded-wait bus timeout.
module stage_mem_hs #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int RA_W     = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [3:0]            ex_op,
    input  logic                  ex_rfwe,
    input  logic [RA_W-1:0]       ex_rfwa,
    input  logic [DATA_W-1:0]     ex_res,
    input  logic [ADDR_W-1:0]     ex_addr,
    input  logic [DATA_W-1:0]     ex_data,
    input  logic [ADDR_W-1:0]     ex_pc,
    output logic                  wb_valid,
    output logic                  wb_rfwe,
    output logic [RA_W-1:0]       wb_rfwa,
    output logic [DATA_W-1:0]     wb_res,
    output logic [ADDR_W-1:0]     wb_pc,
    output logic                  mem_isload,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [DATA_W/8-1:0]   bus_be,
    input  logic                  bus_ack,
    input  logic [DATA_W-1:0]     bus_rdata,
    output logic                  exc_valid,
    output logic [1:0]            exc_code,
    output logic [ADDR_W-1:0]     exc_badaddr
);
    localparam int NB = DATA_W / 8;
    localparam int LW = $clog2(NB);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [1:0] EXC_ADEL   = 2'd1;
    localparam logic [1:0] EXC_ADES   = 2'd2;
    localparam logic [1:0] EXC_BUSERR = 2'd3;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          wcnt_q, wcnt_d;
    logic [3:0]          op_q, op_d;
    logic                rfwe_q, rfwe_d;
    logic [RA_W-1:0]     rfwa_q, rfwa_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;

    logic                wb_valid_q, wb_valid_d;
    logic                wb_rfwe_q, wb_rfwe_d;
    logic [RA_W-1:0]     wb_rfwa_q, wb_rfwa_d;
    logic [DATA_W-1:0]   wb_res_q, wb_res_d;
    logic [ADDR_W-1:0]   wb_pc_q, wb_pc_d;
    logic                exc_valid_q, exc_valid_d;
    logic [1:0]          exc_code_q, exc_code_d;
    logic [ADDR_W-1:0]   exc_badaddr_q, exc_badaddr_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [NB-1:0]       bus_be_q, bus_be_d;

    logic                in_load, in_store, in_half, in_word, misalign;
    logic [NB-1:0]       be_in;
    logic [DATA_W-1:0]   wdata_in;
    logic                held_load;
    logic [DATA_W-1:0]   shifted, load_data;
    logic                unused_bits;

    // Decode of the op being offered by EXE
    always_comb begin
        in_load  = (ex_op >= OP_LB) && (ex_op <= OP_LW);
        in_store = (ex_op >= OP_SB) && (ex_op <= OP_SW);
        in_half  = (ex_op == OP_LH) || (ex_op == OP_LHU) || (ex_op == OP_SH);
        in_word  = (ex_op == OP_LW) || (ex_op == OP_SW);
        misalign = (in_half && ex_addr[0]) || (in_word && (ex_addr[1:0] != 2'b00));
        if (in_word) begin
            be_in    = NB'(4'hF) << ex_addr[LW-1:0];
            wdata_in = {(NB/4){ex_data[31:0]}};
        end else if (in_half) begin
            be_in    = NB'(2'b11) << ex_addr[LW-1:0];
            wdata_in = {(NB/2){ex_data[15:0]}};
        end else begin
            be_in    = NB'(1'b1) << ex_addr[LW-1:0];
            wdata_in = {NB{ex_data[7:0]}};
        end
    end

    // Lane extraction and sign/zero extension of returned read data
    always_comb begin
        held_load = (op_q >= OP_LB) && (op_q <= OP_LW);
        shifted   = bus_rdata >> {addr_q[LW-1:0], 3'b000};
        case (op_q)
            OP_LB:   load_data = DATA_W'($signed(shifted[7:0]));
            OP_LBU:  load_data = DATA_W'(shifted[7:0]);
            OP_LH:   load_data = DATA_W'($signed(shifted[15:0]));
            OP_LHU:  load_data = DATA_W'(shifted[15:0]);
            default: load_data = DATA_W'($signed(shifted[31:0]));
        endcase
    end

    assign unused_bits = ^{ex_data, shifted};

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        op_d          = op_q;
        rfwe_d        = rfwe_q;
        rfwa_d        = rfwa_q;
        res_d         = res_q;
        addr_d        = addr_q;
        pc_d          = pc_q;
        wb_valid_d    = 1'b0;
        wb_rfwe_d     = wb_rfwe_q;
        wb_rfwa_d     = wb_rfwa_q;
        wb_res_d      = wb_res_q;
        wb_pc_d       = wb_pc_q;
        exc_valid_d   = 1'b0;
        exc_code_d    = exc_code_q;
        exc_badaddr_d = exc_badaddr_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_be_d      = bus_be_q;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    op_d   = ex_op;
                    rfwe_d = ex_rfwe;
                    rfwa_d = ex_rfwa;
                    res_d  = ex_res;
                    addr_d = ex_addr;
                    pc_d   = ex_pc;
                    if (!in_load && !in_store) begin
                        wb_valid_d = 1'b1;
                        wb_rfwe_d  = ex_rfwe;
                        wb_rfwa_d  = ex_rfwa;
                        wb_res_d   = ex_res;
                        wb_pc_d    = ex_pc;
                    end else if (misalign) begin
                        exc_valid_d   = 1'b1;
                        exc_code_d    = in_load ? EXC_ADEL : EXC_ADES;
                        exc_badaddr_d = ex_addr;
                        wb_valid_d    = 1'b1;
                        wb_rfwe_d     = 1'b0;
                        wb_rfwa_d     = ex_rfwa;
                        wb_res_d      = ex_res;
                        wb_pc_d       = ex_pc;
                    end else begin
                        state_d     = REQ;
                        wcnt_d      = 8'd0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = in_store;
                        bus_addr_d  = ex_addr & ~ADDR_W'(NB - 1);
                        bus_wdata_d = wdata_in;
                        bus_be_d    = be_in;
                    end
                end
            end
            REQ: begin
                if (bus_ack) begin
                    state_d    = IDLE;
                    bus_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rfwe_d  = rfwe_q;
                    wb_rfwa_d  = rfwa_q;
                    wb_res_d   = held_load ? load_data : res_q;
                    wb_pc_d    = pc_q;
                end else if (wcnt_q == 8'(MAX_WAIT - 1)) begin
                    // Last permitted wait cycle passed without an ack
                    state_d       = IDLE;
                    bus_req_d     = 1'b0;
                    exc_valid_d   = 1'b1;
                    exc_code_d    = EXC_BUSERR;
                    exc_badaddr_d = addr_q;
                    wb_valid_d    = 1'b1;
                    wb_rfwe_d     = 1'b0;
                    wb_rfwa_d     = rfwa_q;
                    wb_res_d      = res_q;
                    wb_pc_d       = pc_q;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wcnt_q        <= '0;
            op_q          <= '0;
            rfwe_q        <= 1'b0;
            rfwa_q        <= '0;
            res_q         <= '0;
            addr_q        <= '0;
            pc_q          <= '0;
            wb_valid_q    <= 1'b0;
            wb_rfwe_q     <= 1'b0;
            wb_rfwa_q     <= '0;
            wb_res_q      <= '0;
            wb_pc_q       <= '0;
            exc_valid_q   <= 1'b0;
            exc_code_q    <= '0;
            exc_badaddr_q <= '0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_be_q      <= '0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            op_q          <= op_d;
            rfwe_q        <= rfwe_d;
            rfwa_q        <= rfwa_d;
            res_q         <= res_d;
            addr_q        <= addr_d;
            pc_q          <= pc_d;
            wb_valid_q    <= wb_valid_d;
            wb_rfwe_q     <= wb_rfwe_d;
            wb_rfwa_q     <= wb_rfwa_d;
            wb_res_q      <= wb_res_d;
            wb_pc_q       <= wb_pc_d;
            exc_valid_q   <= exc_valid_d;
            exc_code_q    <= exc_code_d;
            exc_badaddr_q <= exc_badaddr_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_be_q      <= bus_be_d;
        end
    end

    assign ex_ready    = (state_q == IDLE);
    assign mem_isload  = (state_q == REQ) && held_load;
    assign wb_valid    = wb_valid_q;
    assign wb_rfwe     = wb_rfwe_q;
    assign wb_rfwa     = wb_rfwa_q;
    assign wb_res      = wb_res_q;
    assign wb_pc       = wb_pc_q;
    assign exc_valid   = exc_valid_q;
    assign exc_code    = exc_code_q;
    assign exc_badaddr = exc_badaddr_q;
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_be      = bus_be_q;

endmodule

// File: tb/tb_stage_mem_hs.sv
// tb_stage_mem_hs: runs a 32-bit and a 64-bit stage_mem_hs in lockstep on the
// same stimulus and compares both against a byte-level reference model.
module tb_stage_mem_hs;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic        ex_rfwe;
    logic [4:0]  ex_rfwa;
    logic [63:0] ex_res;
    logic [31:0] ex_addr;
    logic [63:0] ex_data;
    logic [31:0] ex_pc;
    logic        bus_ack;
    logic [63:0] bus_rdata;

    logic        a_ex_ready, a_wb_valid, a_wb_rfwe, a_mem_isload, a_bus_req, a_bus_we, a_exc_valid;
    logic [4:0]  a_wb_rfwa;
    logic [31:0] a_wb_res, a_wb_pc, a_bus_addr, a_bus_wdata, a_exc_badaddr;
    logic [3:0]  a_bus_be;
    logic [1:0]  a_exc_code;

    logic        b_ex_ready, b_wb_valid, b_wb_rfwe, b_mem_isload, b_bus_req, b_bus_we, b_exc_valid;
    logic [4:0]  b_wb_rfwa;
    logic [63:0] b_wb_res, b_bus_wdata;
    logic [31:0] b_wb_pc, b_bus_addr, b_exc_badaddr;
    logic [7:0]  b_bus_be;
    logic [1:0]  b_exc_code;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stage_mem_hs #(.DATA_W(32), .ADDR_W(32), .RA_W(5), .MAX_WAIT(MAX_WAIT)) dut_a (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(a_ex_ready), .ex_op(ex_op),
        .ex_rfwe(ex_rfwe), .ex_rfwa(ex_rfwa), .ex_res(ex_res[31:0]),
        .ex_addr(ex_addr), .ex_data(ex_data[31:0]), .ex_pc(ex_pc),
        .wb_valid(a_wb_valid), .wb_rfwe(a_wb_rfwe), .wb_rfwa(a_wb_rfwa),
        .wb_res(a_wb_res), .wb_pc(a_wb_pc), .mem_isload(a_mem_isload),
        .bus_req(a_bus_req), .bus_we(a_bus_we), .bus_addr(a_bus_addr),
        .bus_wdata(a_bus_wdata), .bus_be(a_bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata[31:0]),
        .exc_valid(a_exc_valid), .exc_code(a_exc_code), .exc_badaddr(a_exc_badaddr)
    );

    stage_mem_hs #(.DATA_W(64), .ADDR_W(32), .RA_W(5), .MAX_WAIT(MAX_WAIT)) dut_b (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(b_ex_ready), .ex_op(ex_op),
        .ex_rfwe(ex_rfwe), .ex_rfwa(ex_rfwa), .ex_res(ex_res),
        .ex_addr(ex_addr), .ex_data(ex_data), .ex_pc(ex_pc),
        .wb_valid(b_wb_valid), .wb_rfwe(b_wb_rfwe), .wb_rfwa(b_wb_rfwa),
        .wb_res(b_wb_res), .wb_pc(b_wb_pc), .mem_isload(b_mem_isload),
        .bus_req(b_bus_req), .bus_we(b_bus_we), .bus_addr(b_bus_addr),
        .bus_wdata(b_bus_wdata), .bus_be(b_bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .exc_valid(b_exc_valid), .exc_code(b_exc_code), .exc_badaddr(b_exc_badaddr)
    );

    // Access size in bytes for an op code; 0 means the op does no memory access
    function automatic int opSize(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            4'd5, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic bit opIsLoad(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic logic [63:0] expLoad(input logic [3:0] op, input logic [63:0] rdata,
                                            input int lane, input int dw);
        logic [63:0] v;
        logic [63:0] m;
        int size;
        size = opSize(op);
        m = (64'd1 << (8 * size)) - 64'd1;
        v = (rdata >> (8 * lane)) & m;
        if ((op == 4'd1 || op == 4'd3 || op == 4'd5) && v[8*size-1])
            v = v | ~m;
        if (dw == 32)
            v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    function automatic logic [63:0] expBe(input logic [3:0] op, input int lane);
        return ((64'd1 << opSize(op)) - 64'd1) << lane;
    endfunction

    function automatic logic [63:0] expWdata(input logic [3:0] op, input logic [63:0] data,
                                             input int nb);
        logic [63:0] w;
        int size;
        size = opSize(op);
        w = '0;
        for (int i = 0; i < nb; i++)
            w[8*i +: 8] = data[8*(i % size) +: 8];
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".a.ready"}, a_ex_ready, 1);
        checkOutput({tag, ".b.ready"}, b_ex_ready, 1);
        checkOutput({tag, ".a.isload"}, a_mem_isload, 0);
        checkOutput({tag, ".b.isload"}, b_mem_isload, 0);
        checkOutput({tag, ".a.wb"}, {a_wb_valid, a_wb_rfwe, a_wb_rfwa, a_wb_res, a_wb_pc}, 0);
        checkOutput({tag, ".b.wbres"}, b_wb_res, 0);
        checkOutput({tag, ".b.wb"}, {b_wb_valid, b_wb_rfwe, b_wb_rfwa, b_wb_pc}, 0);
        checkOutput({tag, ".a.exc"}, {a_exc_valid, a_exc_code, a_exc_badaddr}, 0);
        checkOutput({tag, ".b.exc"}, {b_exc_valid, b_exc_code, b_exc_badaddr}, 0);
        checkOutput({tag, ".a.bus"}, {a_bus_req, a_bus_we, a_bus_be, a_bus_addr}, 0);
        checkOutput({tag, ".b.bus"}, {b_bus_req, b_bus_we, b_bus_be, b_bus_addr}, 0);
        checkOutput({tag, ".a.wdata"}, a_bus_wdata, 0);
        checkOutput({tag, ".b.wdata"}, b_bus_wdata, 0);
    endtask

    // One instruction through both DUTs; ackDelay = wait cycles before ack, >= MAX_WAIT times out
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [63:0] data, input logic [63:0] res,
                                 input logic [31:0] pc, input logic rfwe, input logic [4:0] rfwa,
                                 input logic [63:0] rdata, input int ackDelay);
        int  size;
        bit  ld;
        bit  mis;
        int  k;
        bit  acked;
        size = opSize(op);
        ld   = opIsLoad(op);
        mis  = (size > 1) && ((addr % size) != 0);

        checkOutput("accept.a.ready", a_ex_ready, 1);
        checkOutput("accept.b.ready", b_ex_ready, 1);
        ex_valid = 1'b1;
        ex_op    = op;
        ex_addr  = addr;
        ex_data  = data;
        ex_res   = res;
        ex_pc    = pc;
        ex_rfwe  = rfwe;
        ex_rfwa  = rfwa;
        bus_ack  = 1'($urandom_range(0, 1));
        @(negedge clk);
        ex_valid = 1'b0;
        ex_op    = 4'($urandom);
        ex_addr  = $urandom;
        ex_data  = {$urandom, $urandom};
        ex_res   = {$urandom, $urandom};
        ex_pc    = $urandom;
        ex_rfwe  = 1'($urandom);
        ex_rfwa  = 5'($urandom);
        bus_ack  = 1'b0;

        if (size == 0) begin
            checkOutput("none.a.wbvalid", a_wb_valid, 1);
            checkOutput("none.b.wbvalid", b_wb_valid, 1);
            checkOutput("none.a.wbpc", a_wb_pc, pc);
            checkOutput("none.b.wbpc", b_wb_pc, pc);
            checkOutput("none.a.wbres", a_wb_res, res & 64'hFFFF_FFFF);
            checkOutput("none.b.wbres", b_wb_res, res);
            checkOutput("none.a.wbrf", {a_wb_rfwe, a_wb_rfwa}, {rfwe, rfwa});
            checkOutput("none.b.wbrf", {b_wb_rfwe, b_wb_rfwa}, {rfwe, rfwa});
            checkOutput("none.a.quiet", {a_exc_valid, a_bus_req, a_mem_isload}, 0);
            checkOutput("none.b.quiet", {b_exc_valid, b_bus_req, b_mem_isload}, 0);
        end else if (mis) begin
            checkOutput("mis.a.exc", {a_exc_valid, a_exc_code}, {1'b1, ld ? 2'd1 : 2'd2});
            checkOutput("mis.b.exc", {b_exc_valid, b_exc_code}, {1'b1, ld ? 2'd1 : 2'd2});
            checkOutput("mis.a.badaddr", a_exc_badaddr, addr);
            checkOutput("mis.b.badaddr", b_exc_badaddr, addr);
            checkOutput("mis.a.wb", {a_wb_valid, a_wb_rfwe}, 2'b10);
            checkOutput("mis.b.wb", {b_wb_valid, b_wb_rfwe}, 2'b10);
            checkOutput("mis.a.wbpc", a_wb_pc, pc);
            checkOutput("mis.b.wbpc", b_wb_pc, pc);
            checkOutput("mis.a.noreq", {a_bus_req, a_ex_ready}, 2'b01);
            checkOutput("mis.b.noreq", {b_bus_req, b_ex_ready}, 2'b01);
        end else begin
            k = 1;
            acked = 1'b0;
            while (k <= MAX_WAIT) begin
                checkOutput("req.a.reqwe", {a_bus_req, a_bus_we}, {1'b1, !ld});
                checkOutput("req.b.reqwe", {b_bus_req, b_bus_we}, {1'b1, !ld});
                checkOutput("req.a.addr", a_bus_addr, addr - (addr % 4));
                checkOutput("req.b.addr", b_bus_addr, addr - (addr % 8));
                checkOutput("req.a.be", a_bus_be, expBe(op, int'(addr % 4)));
                checkOutput("req.b.be", b_bus_be, expBe(op, int'(addr % 8)));
                if (!ld) begin
                    checkOutput("req.a.wdata", a_bus_wdata, expWdata(op, data, 4));
                    checkOutput("req.b.wdata", b_bus_wdata, expWdata(op, data, 8));
                end
                checkOutput("req.a.ready", {a_ex_ready, a_mem_isload, a_wb_valid}, {1'b0, ld, 1'b0});
                checkOutput("req.b.ready", {b_ex_ready, b_mem_isload, b_wb_valid}, {1'b0, ld, 1'b0});
                if (k - 1 == ackDelay) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rdata;
                    @(negedge clk);
                    bus_ack   = 1'b0;
                    bus_rdata = {$urandom, $urandom};
                    acked = 1'b1;
                    break;
                end
                bus_rdata = {$urandom, $urandom};
                @(negedge clk);
                k++;
            end
            if (acked) begin
                checkOutput("ack.a.wb", {a_wb_valid, a_wb_rfwe, a_wb_rfwa}, {1'b1, rfwe, rfwa});
                checkOutput("ack.b.wb", {b_wb_valid, b_wb_rfwe, b_wb_rfwa}, {1'b1, rfwe, rfwa});
                checkOutput("ack.a.wbres", a_wb_res,
                            ld ? expLoad(op, {32'd0, rdata[31:0]}, int'(addr % 4), 32)
                               : (res & 64'hFFFF_FFFF));
                checkOutput("ack.b.wbres", b_wb_res,
                            ld ? expLoad(op, rdata, int'(addr % 8), 64) : res);
                checkOutput("ack.a.wbpc", a_wb_pc, pc);
                checkOutput("ack.b.wbpc", b_wb_pc, pc);
                checkOutput("ack.a.idle", {a_bus_req, a_ex_ready, a_exc_valid, a_mem_isload}, 4'b0100);
                checkOutput("ack.b.idle", {b_bus_req, b_ex_ready, b_exc_valid, b_mem_isload}, 4'b0100);
            end else begin
                checkOutput("tmo.a.exc", {a_bus_req, a_exc_valid, a_exc_code}, {2'b01, 2'd3});
                checkOutput("tmo.b.exc", {b_bus_req, b_exc_valid, b_exc_code}, {2'b01, 2'd3});
                checkOutput("tmo.a.badaddr", a_exc_badaddr, addr);
                checkOutput("tmo.b.badaddr", b_exc_badaddr, addr);
                checkOutput("tmo.a.wb", {a_wb_valid, a_wb_rfwe, a_ex_ready}, 3'b101);
                checkOutput("tmo.b.wb", {b_wb_valid, b_wb_rfwe, b_ex_ready}, 3'b101);
                bus_ack = 1'b1;
                @(negedge clk);
                bus_ack = 1'b0;
                checkOutput("late.a.ignored", {a_wb_valid, a_exc_valid, a_bus_req}, 0);
                checkOutput("late.b.ignored", {b_wb_valid, b_exc_valid, b_bus_req}, 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the run ended");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0]  rop;
        logic [31:0] raddr;
        int          rdly;

        rst       = 1'b1;
        ex_valid  = 1'b0;
        ex_op     = 4'd0;
        ex_rfwe   = 1'b0;
        ex_rfwa   = 5'd0;
        ex_res    = '0;
        ex_addr   = '0;
        ex_data   = '0;
        ex_pc     = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;

        applyStimulus(4'd1, 32'h1003, 64'h0, 64'h11, 32'h100, 1'b1, 5'd3,
                      64'h5555_5555_80FF_FF12, 0);
        applyStimulus(4'd4, 32'h2002, 64'h0, 64'h22, 32'h104, 1'b1, 5'd4,
                      64'h0000_0000_BEEF_1234, 3);
        applyStimulus(4'd6, 32'h3001, 64'h1234_56A5, 64'hCAFE, 32'h108, 1'b0, 5'd0,
                      64'h0, 1);
        applyStimulus(4'd5, 32'h4004, 64'h0, 64'h33, 32'h10C, 1'b1, 5'd7,
                      64'h8000_0000_0000_0000, 0);
        applyStimulus(4'd5, 32'h5002, 64'h0, 64'h44, 32'h110, 1'b1, 5'd8, 64'h0, 0);
        applyStimulus(4'd7, 32'h5001, 64'hABCD, 64'h55, 32'h114, 1'b0, 5'd9, 64'h0, 0);
        applyStimulus(4'd8, 32'h6000, 64'hDEAD_BEEF, 64'h66, 32'h118, 1'b0, 5'd0, 64'h0, MAX_WAIT);

        for (int i = 0; i < 6; i++)
            applyStimulus((i % 2 == 0) ? 4'd0 : 4'(9 + i), $urandom, {$urandom, $urandom},
                          {$urandom, $urandom}, 32'h200 + 32'(4 * i), 1'($urandom),
                          5'($urandom), 64'h0, 0);

        // Reset asserted in the second request cycle of a load abandons it
        ex_valid = 1'b1;
        ex_op    = 4'd5;
        ex_addr  = 32'h7008;
        ex_pc    = 32'h300;
        ex_rfwe  = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        checkOutput("rstreq.a.req", a_bus_req, 1);
        checkOutput("rstreq.b.req", b_bus_req, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkResetState("rstreq");
        rst = 1'b0;
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        checkResetState("rstreq.after");

        for (int i = 0; i < 40; i++) begin
            rop   = 4'($urandom_range(0, 15));
            raddr = $urandom;
            if ($urandom_range(0, 3) != 0 && opSize(rop) > 1)
                raddr = raddr - (raddr % opSize(rop));
            rdly = ($urandom_range(0, 9) == 0) ? MAX_WAIT : int'($urandom_range(0, 4));
            applyStimulus(rop, raddr, {$urandom, $urandom}, {$urandom, $urandom}, $urandom,
                          1'($urandom), 5'($urandom), {$urandom, $urandom}, rdly);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
